fifo_rd_packer: RTL and testbench

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_rd_packer.sv | 126 ++++++++++++
 tb/tb_fifo_rd_packer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Pops bytes from a 1-cycle-latency FIFO read port and packs them into LANES-wide
// words, closing a word when it is full or its last byte carries the end-of-packet flag.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   rd_clk,
  input  logic                   rd_reset,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [WIDTH:0]         fifo_out,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LANES*WIDTH-1:0] m_data,
  output logic [LANES-1:0]       m_keep,
  output logic                   m_last,
  output logic [15:0]            pkt_cnt
);

  localparam int CW = $clog2(LANES + 1);
  localparam logic [CW:0]   LANES_X = (CW+1)'(LANES);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);

  typedef enum logic {COLLECT, OUTPUT} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   pend;
  logic                   carry_v, carry_v_n;
  logic [WIDTH:0]         carry_q, carry_n;
  logic [LANES*WIDTH-1:0] data_n;
  logic [LANES-1:0]       keep_n;
  logic                   last_n;
  logic [15:0]            pkt_n;
  logic [1:0]             guard;

  logic                   guard_done;
  logic                   room;
  logic [WIDTH:0]         first_byte;

  assign guard_done = guard[1];
  assign room       = ({1'b0, cnt} + {{CW{1'b0}}, pend}) < LANES_X;
  assign fifo_rd_en = (state == COLLECT) && !fifo_empty && !carry_v && room && guard_done;
  assign m_valid    = (state == OUTPUT);
  // A parked carry byte always predates any byte arriving in the handshake cycle.
  assign first_byte = carry_v ? carry_q : fifo_out;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    carry_v_n = carry_v;
    carry_n   = carry_q;
    data_n    = m_data;
    keep_n    = m_keep;
    last_n    = m_last;
    pkt_n     = pkt_cnt;
    unique case (state)
      COLLECT: begin
        if (pend) begin
          for (int i = 0; i < LANES; i++) begin
            if (cnt == CW'(i)) begin
              data_n[i*WIDTH +: WIDTH] = fifo_out[WIDTH-1:0];
              keep_n[i]                = 1'b1;
            end
          end
          cnt_n  = cnt + CW'(1);
          last_n = fifo_out[WIDTH];
          if (cnt_n == LANES_C || fifo_out[WIDTH]) state_n = OUTPUT;
        end
      end
      OUTPUT: begin
        if (m_ready) begin
          pkt_n     = pkt_cnt + {15'd0, m_last};
          data_n    = '0;
          keep_n    = '0;
          last_n    = 1'b0;
          cnt_n     = '0;
          carry_v_n = 1'b0;
          state_n   = COLLECT;
          if (carry_v || pend) begin
            data_n[WIDTH-1:0] = first_byte[WIDTH-1:0];
            keep_n            = {{(LANES-1){1'b0}}, 1'b1};
            cnt_n             = CW'(1);
            // A lone end-of-packet byte forms a complete word on its own.
            if (first_byte[WIDTH]) begin
              last_n  = 1'b1;
              state_n = OUTPUT;
            end
          end
        end else if (pend) begin
          carry_v_n = 1'b1;
          carry_n   = fifo_out;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_reset) begin
    if (!rd_reset) begin
      state   <= COLLECT;
      cnt     <= '0;
      pend    <= 1'b0;
      carry_v <= 1'b0;
      carry_q <= '0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
      pkt_cnt <= '0;
      guard   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pend    <= fifo_rd_en;
      carry_v <= carry_v_n;
      carry_q <= carry_n;
      m_data  <= data_n;
      m_keep  <= keep_n;
      m_last  <= last_n;
      pkt_cnt <= pkt_n;
      // The upstream empty flag is meaningless until it has been registered once.
      if (!guard_done) guard <= guard + 2'd1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: emulates the upstream FIFO and checks each output word
// against words formed directly from the pushed byte stream.
module tb_fifo_rd_packer;
  localparam int WIDTH = 8;
  localparam int LANES = 4;

  logic                   rd_clk = 1'b0;
  logic                   rd_reset;
  logic                   fifo_empty;
  logic                   fifo_rd_en;
  logic [WIDTH:0]         fifo_out;
  logic                   m_valid;
  logic                   m_ready;
  logic [LANES*WIDTH-1:0] m_data;
  logic [LANES-1:0]       m_keep;
  logic                   m_last;
  logic [15:0]            pkt_cnt;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_packer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .rd_clk(rd_clk), .rd_reset(rd_reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_out(fifo_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_keep(m_keep), .m_last(m_last), .pkt_cnt(pkt_cnt)
  );

  typedef struct {
    logic [LANES*WIDTH-1:0] data;
    logic [LANES-1:0]       keep;
    logic                   last;
  } word_t;

  word_t          exp_q[$];
  logic [WIDTH:0] src_q[$];
  logic [WIDTH-1:0] cur_bytes[$];
  int compared   = 0;
  int mismatched = 0;
  int exp_pkt    = 0;
  bit rand_ready = 1'b0;
  bit stall_en   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Words are closed by a full lane set or by the end-of-packet byte.
  function automatic void push_byte(input logic [WIDTH-1:0] b, input logic last);
    word_t w;
    src_q.push_back({last, b});
    cur_bytes.push_back(b);
    if (last || cur_bytes.size() == LANES) begin
      w.data = '0;
      w.keep = '0;
      foreach (cur_bytes[i]) begin
        w.data[i*WIDTH +: WIDTH] = cur_bytes[i];
        w.keep[i] = 1'b1;
      end
      w.last = last;
      exp_q.push_back(w);
      cur_bytes.delete();
    end
  endfunction

  task automatic cycle();
    logic  pop, hs;
    word_t w;
    @(negedge rd_clk);
    pop = fifo_rd_en && !fifo_empty;
    hs  = m_valid && m_ready;
    if (m_valid) chk("rd_en_in_output", 64'(fifo_rd_en), 64'd0);
    if (hs) begin
      chk("word_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        chk("m_data", 64'(m_data), 64'(w.data));
        chk("m_keep", 64'(m_keep), 64'(w.keep));
        chk("m_last", 64'(m_last), 64'(w.last));
        if (w.last) exp_pkt++;
      end
    end
    @(posedge rd_clk);
    #1;
    if (hs) chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    if (pop && src_q.size() > 0) fifo_out = src_q.pop_front();
    else fifo_out = 9'($urandom);
    fifo_empty = (src_q.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || src_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (4) cycle();
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!m_valid && n < budget) begin
      cycle();
      n++;
    end
    chk("wait_valid", 64'(m_valid), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_m_data"}, 64'(m_data), 64'd0);
    chk({tag, "_m_keep"}, 64'(m_keep), 64'd0);
    chk({tag, "_m_last"}, 64'(m_last), 64'd0);
    chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
    chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
  endtask

  initial begin
    rd_reset   = 1'b1;
    fifo_empty = 1'b1;
    fifo_out   = '0;
    m_ready    = 1'b1;
    #2 rd_reset = 1'b0;

    // Reset state, then the empty-flag guard after release with fifo_empty held low.
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b0);
    push_byte(8'h44, 1'b1);
    fifo_empty = 1'b0;
    repeat (2) @(posedge rd_clk);
    #1;
    check_reset_outputs("reset");
    rd_reset = 1'b1;
    chk("guard_edge0", 64'(fifo_rd_en), 64'd0);
    @(posedge rd_clk); #1;
    chk("guard_edge1", 64'(fifo_rd_en), 64'd0);
    @(posedge rd_clk); #1;
    chk("guard_open", 64'(fifo_rd_en), 64'd1);
    drain(100);
    chk("pkt_cnt_full_word", 64'(pkt_cnt), 64'd1);

    // Short packet held under back-pressure while the next byte parks in carry.
    m_ready = 1'b0;
    push_byte(8'hA1, 1'b0);
    push_byte(8'hA2, 1'b1);
    push_byte(8'hB1, 1'b0);
    push_byte(8'hB2, 1'b0);
    push_byte(8'hB3, 1'b1);
    fifo_empty = 1'b0;
    wait_valid(50);
    repeat (3) begin
      chk("hold_data", 64'(m_data), 64'h0000A2A1);
      chk("hold_keep", 64'(m_keep), 64'h3);
      chk("hold_last", 64'(m_last), 64'd1);
      cycle();
    end
    m_ready = 1'b1;
    drain(100);
    chk("pkt_cnt_backpressure", 64'(pkt_cnt), 64'd3);

    // Single-byte packet taken from carry at the handshake stays in OUTPUT.
    m_ready = 1'b0;
    push_byte(8'hC1, 1'b1);
    push_byte(8'h7F, 1'b1);
    fifo_empty = 1'b0;
    wait_valid(50);
    repeat (2) cycle();
    m_ready = 1'b1;
    cycle();
    chk("single_valid", 64'(m_valid), 64'd1);
    chk("single_data", 64'(m_data), 64'h0000007F);
    chk("single_keep", 64'(m_keep), 64'h1);
    chk("single_last", 64'(m_last), 64'd1);
    drain(100);

    // Nine bytes without an end flag: two full words, ninth byte left in lane 0.
    for (int i = 1; i <= 9; i++) push_byte(8'(i), 1'b0);
    fifo_empty = 1'b0;
    drain(200);
    chk("residue_valid", 64'(m_valid), 64'd0);
    chk("residue_keep", 64'(m_keep), 64'h1);
    chk("residue_data", 64'(m_data), 64'h00000009);

    // Reset mid-packet with two lanes filled and a byte in carry.
    m_ready = 1'b0;
    push_byte(8'hE1, 1'b1);
    push_byte(8'hE2, 1'b0);
    push_byte(8'hE3, 1'b1);
    fifo_empty = 1'b0;
    wait_valid(50);
    repeat (2) cycle();
    chk("pre_reset_keep", 64'(m_keep), 64'h3);
    chk("pre_reset_data", 64'(m_data), 64'h0000E109);
    rd_reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    src_q.delete();
    exp_q.delete();
    cur_bytes.delete();
    exp_pkt = 0;
    m_ready = 1'b1;
    repeat (2) @(posedge rd_clk);
    #1;
    push_byte(8'hD1, 1'b0);
    push_byte(8'hD2, 1'b0);
    push_byte(8'hD3, 1'b0);
    push_byte(8'hD4, 1'b1);
    fifo_empty = 1'b0;
    rd_reset = 1'b1;
    drain(100);
    chk("pkt_cnt_after_reset", 64'(pkt_cnt), 64'd1);

    // Random bytes and end flags with random back-pressure and empty stalls.
    stall_en   = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++)
      push_byte(8'($urandom), (i == 299) || ($urandom_range(0, 4) == 0));
    fifo_empty = 1'b0;
    drain(20000);
    chk("pkt_cnt_random", 64'(pkt_cnt), 64'(exp_pkt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
